// File: rtl/soc_sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding and the
// word addresses of the ID and timestamp registers on the sysid slave.
package soc_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int SYSID_CNT_W = 16;

endpackage

// File: rtl/soc_sysid_checker.sv
// Reads the system ID (word 0) and build timestamp (word 1) over Avalon-MM,
// compares both against the expected values and reports the outcome with a
// one-cycle done pulse. Each read is bounded by TIMEOUT_CYCLES.
module soc_sysid_checker
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1672894844,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic        avm_read,
    output logic        avm_address,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid
);

    localparam logic [SYSID_CNT_W-1:0] CNT_MAX  = SYSID_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [SYSID_CNT_W-1:0] CNT_LAST = SYSID_CNT_W'(TIMEOUT_CYCLES - 1);

    sysid_state_e           state;
    logic [SYSID_CNT_W-1:0] cnt;
    logic [SYSID_CNT_W-1:0] cnt_next;

    logic in_req;
    logic in_wait;
    logic is_ts;
    logic launch;
    logic xfer_done;
    logic xfer_expired;

    assign in_req   = (state == REQ_ID)  || (state == REQ_TS);
    assign in_wait  = (state == WAIT_ID) || (state == WAIT_TS);
    assign is_ts    = (state == REQ_TS)  || (state == WAIT_TS);
    assign launch   = start && ((state == IDLE) || (state == FINISH));
    assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Data lands either in WAIT_x, or in REQ_x on the very cycle the command
    // is accepted (zero-latency slave). A landing beat beats the timeout.
    assign xfer_done    = (in_req && !avm_waitrequest && avm_readdatavalid) ||
                          (in_wait && avm_readdatavalid);
    assign xfer_expired = (in_req || in_wait) && !xfer_done && (cnt == CNT_LAST);

    // Check sequencer: state, bus command, per-read counter and result flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            captured_id <= '0;
            captured_ts <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            if (in_req || in_wait)
                cnt <= cnt_next;

            if (launch) begin
                state       <= REQ_ID;
                avm_read    <= 1'b1;
                avm_address <= SYSID_ADDR_ID;
                busy        <= 1'b1;
                cnt         <= '0;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout     <= 1'b0;
            end else if (xfer_done && !is_ts) begin
                captured_id <= avm_readdata;
                state       <= REQ_TS;
                avm_read    <= 1'b1;
                avm_address <= SYSID_ADDR_TS;
                cnt         <= '0;
            end else if (xfer_done) begin
                // The timestamp being captured this cycle is compared directly.
                captured_ts <= avm_readdata;
                state       <= FINISH;
                avm_read    <= 1'b0;
                done        <= 1'b1;
                id_ok       <= (captured_id == EXPECTED_ID);
                ts_ok       <= (avm_readdata == EXPECTED_TS);
            end else if (xfer_expired) begin
                state       <= FINISH;
                avm_read    <= 1'b0;
                done        <= 1'b1;
                timeout     <= 1'b1;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
            end else if (in_req && !avm_waitrequest) begin
                state       <= is_ts ? WAIT_TS : WAIT_ID;
                avm_read    <= 1'b0;
            end else if (!in_req && !in_wait && (state != IDLE)) begin
                // FINISH without a new start, and any unused encoding, fall back to IDLE.
                state       <= IDLE;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Randomized self-checking bench for soc_sysid_checker. A behavioural slave
// supplies configurable waitrequest / read-latency per word; a transaction
// level model predicts done timing, captures and result flags per check.
module tb_soc_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1672894844;
    localparam int          TB_T   = 8;
    localparam int          NEVER  = 1000;   // read latency: data never returned
    localparam int          STUCK  = 1000;   // wait cycles: waitrequest never drops

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;
    logic        avm_read, avm_address;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // slave configuration, index 0 = ID word, 1 = TS word
    int          w_cfg [2] = '{0, 0};
    int          l_cfg [2] = '{1, 1};
    logic [31:0] d_cfg [2] = '{EXP_ID, EXP_TS};

    // model of the last captured words
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    soc_sysid_checker #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(TB_T)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout          (timeout),
        .captured_id      (captured_id),
        .captured_ts      (captured_ts),
        .avm_read         (avm_read),
        .avm_address      (avm_address),
        .avm_readdata     (avm_readdata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural Avalon slave, driven on the falling edge.
    int   wcnt = 0;
    int   pend = 0;
    logic addr_l = 1'b0;
    bit   prev_hold = 0;
    logic prev_addr = 1'b0;
    always @(negedge clock) begin
        if (prev_hold && wcnt < TB_T) begin
            chk("hold_read", 32'(avm_read), 32'd1);
            chk("hold_addr", 32'(avm_address), 32'(prev_addr));
        end
        prev_hold         = 0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom();
        avm_waitrequest   = 1'($urandom_range(0, 1));
        if (!reset_n) begin
            wcnt = 0;
            pend = 0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = d_cfg[addr_l];
            end
        end else if (avm_read) begin
            if (wcnt < w_cfg[avm_address]) begin
                avm_waitrequest = 1'b1;
                wcnt++;
                prev_hold = 1;
                prev_addr = avm_address;
            end else begin
                avm_waitrequest = 1'b0;
                wcnt   = 0;
                addr_l = avm_address;
                if (l_cfg[addr_l] == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = d_cfg[addr_l];
                end else if (l_cfg[addr_l] != NEVER) begin
                    pend = l_cfg[addr_l];
                end
            end
        end else begin
            wcnt = 0;
            if (!busy && $urandom_range(0, 3) == 0)
                avm_readdatavalid = 1'b1;   // stray beat while idle
        end
    end

    // One check, entered and left on a falling edge. A read with w wait
    // cycles and latency l completes after w+l+1 cycles if w+l <= T-1,
    // otherwise it times out after T cycles.
    task automatic run_check(input int wi, input int li, input int wt, input int lt,
                             input logic [31:0] sid, input logic [31:0] sts,
                             input bit noise, input bit b2b_req);
        bit ok1, ok2, b2b;
        int n;
        w_cfg = '{wi, wt};
        l_cfg = '{li, lt};
        d_cfg = '{sid, sts};
        ok1 = (wi + li) <= TB_T - 1;
        ok2 = ok1 && ((wt + lt) <= TB_T - 1);
        n   = ok1 ? (wi + li + 1) + (ok2 ? (wt + lt + 1) : TB_T) : TB_T;
        if (ok1) m_id = sid;
        if (ok2) m_ts = sts;
        b2b = b2b_req && ok2;
        start = 1'b1;
        @(posedge clock);
        for (int j = 0; j <= n; j++) begin
            @(negedge clock);
            start = (j < n) && noise && (j < 2 || $urandom_range(0, 2) == 0);
            if (j == n && b2b) start = 1'b1;
            chk("done", 32'(done), 32'(j == n));
            chk("busy", 32'(busy), 32'd1);
            if (j == 0) begin
                chk("clr_id_ok", 32'(id_ok), 32'd0);
                chk("clr_ts_ok", 32'(ts_ok), 32'd0);
                chk("clr_timeout", 32'(timeout), 32'd0);
                chk("req_id_read", 32'(avm_read), 32'd1);
                chk("req_id_addr", 32'(avm_address), 32'd0);
            end
            if (j == n) begin
                chk("timeout", 32'(timeout), 32'(!ok2));
                chk("id_ok", 32'(id_ok), 32'(ok2 && m_id == EXP_ID));
                chk("ts_ok", 32'(ts_ok), 32'(ok2 && m_ts == EXP_TS));
                chk("captured_id", captured_id, m_id);
                chk("captured_ts", captured_ts, m_ts);
                chk("fin_read", 32'(avm_read), 32'd0);
            end
        end
        if (!b2b) begin
            start = 1'b0;
            for (int g = 0; g < 6; g++) begin
                @(negedge clock);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_id_ok"}, 32'(id_ok), 32'd0);
        chk({tag, "_ts_ok"}, 32'(ts_ok), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_cap_id"}, captured_id, 32'd0);
        chk({tag, "_cap_ts"}, captured_ts, 32'd0);
        chk({tag, "_read"}, 32'(avm_read), 32'd0);
        chk({tag, "_addr"}, 32'(avm_address), 32'd0);
    endtask

    function automatic int pick_w();
        return ($urandom_range(0, 9) == 0) ? STUCK : int'($urandom_range(0, 4));
    endfunction

    function automatic int pick_l();
        return ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 4));
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_state("rst");
        reset_n = 1'b1;
        @(negedge clock);

        run_check(0, 1, 0, 1, EXP_ID, EXP_TS, 0, 0);          // nominal
        run_check(0, 1, 0, 1, EXP_ID, 32'h1234_5678, 0, 0);   // timestamp mismatch
        run_check(3, 1, 3, 1, EXP_ID, EXP_TS, 0, 0);          // backpressure
        run_check(0, 0, 2, 0, 32'hDEAD_BEEF, EXP_TS, 0, 0);   // zero-latency slave
        run_check(0, NEVER, 0, 1, EXP_ID, EXP_TS, 0, 0);      // timeout on ID
        run_check(0, 1, 0, NEVER, EXP_ID, EXP_TS, 0, 0);      // timeout on TS
        run_check(STUCK, 1, 0, 1, EXP_ID, EXP_TS, 0, 0);      // waitrequest stuck
        run_check(3, 4, 4, 3, EXP_ID, EXP_TS, 0, 0);          // lands on last cycle
        run_check(4, 4, 0, 1, EXP_ID, EXP_TS, 0, 0);          // one cycle too late
        run_check(0, 1, 0, 1, EXP_ID, EXP_TS, 1, 0);          // start while busy
        run_check(0, 1, 0, 1, EXP_ID, EXP_TS, 0, 1);          // start in FINISH
        run_check(1, 0, 0, 2, EXP_ID, EXP_TS ^ 32'h8000_0000, 0, 0);

        // reset while waiting for the timestamp
        w_cfg = '{0, 0};
        l_cfg = '{1, NEVER};
        d_cfg = '{32'hA5A5_0001, EXP_TS};
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_cap_id", captured_id, 32'hA5A5_0001);
        reset_n = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        @(negedge clock);
        reset_n = 1'b1;
        m_id = '0;
        m_ts = '0;
        repeat (4) begin
            @(negedge clock);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        run_check(0, 1, 0, 1, EXP_ID, EXP_TS, 0, 0);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] sid, sts;
            sid = $urandom_range(0, 1) ? EXP_ID : $urandom();
            case ($urandom_range(0, 2))
                0:       sts = EXP_TS;
                1:       sts = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
                default: sts = $urandom();
            endcase
            run_check(pick_w(), pick_l(), pick_w(), pick_l(), sid, sts,
                      $urandom_range(0, 3) == 0, (k < 59) && ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/soc_sysid_checker.md
SOC_SYSID_CHECKER -- requirements
Module: soc_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, meaning the system ID value expected at word 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1672894844, meaning the build timestamp expected at word 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum cycles allowed per read transaction (range 2..65535).
REQ-004 SHALL have ports: clock in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: start in 1, single-cycle request to run a check; busy out 1, check in progress.
REQ-006 SHALL have ports: done out 1, one-cycle pulse at check completion; id_ok out 1; ts_ok out 1; timeout out 1, sticky per check.
REQ-007 SHALL have ports: captured_id out 32; captured_ts out 32, the last words read.
REQ-008 SHALL have Avalon-MM master ports: avm_read out 1; avm_address out 1; avm_readdata in 32; avm_waitrequest in 1; avm_readdatavalid in 1.

Function
REQ-009 SHALL implement FSM states IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
REQ-010 SHALL leave IDLE for REQ_ID on the cycle after start=1 is sampled in IDLE, or in FINISH.
REQ-011 SHALL ignore start in REQ_ID, WAIT_ID, REQ_TS and WAIT_TS.
REQ-012 SHALL drive avm_read=1 with avm_address=0 in REQ_ID and with avm_address=1 in REQ_TS; avm_read=0 in all other states.
REQ-013 SHALL hold avm_read and avm_address stable while avm_waitrequest=1, and advance REQ_x->WAIT_x on the first cycle with avm_waitrequest=0.
REQ-014 SHALL, in WAIT_x, capture avm_readdata into captured_id or captured_ts on the cycle avm_readdatavalid=1, then advance WAIT_ID->REQ_TS or WAIT_TS->FINISH.
REQ-015 SHALL accept avm_readdatavalid=1 in the same cycle that avm_waitrequest falls, capturing the data and skipping WAIT_x (zero-latency slave support).
REQ-016 SHALL ignore avm_readdatavalid in IDLE, REQ_x (unless as in REQ-015) and FINISH.
REQ-017 SHALL run a 16-bit cycle counter cleared on entry to each REQ_x state, incrementing each cycle in REQ_x/WAIT_x, saturating at TIMEOUT_CYCLES.
REQ-018 SHALL, when the counter reaches TIMEOUT_CYCLES-1 without completing the transaction, set timeout=1, deassert avm_read, and go to FINISH without capturing.
REQ-019 SHALL, in FINISH, assert done=1 for exactly one cycle, with id_ok=(captured_id==EXPECTED_ID) and ts_ok=(captured_ts==EXPECTED_TS), both forced 0 if timeout=1; the FSM then returns to IDLE.
REQ-020 SHALL assert busy=1 in every state other than IDLE.
REQ-021 SHALL clear id_ok, ts_ok and timeout on leaving IDLE for REQ_ID; captured_* SHALL retain old values until overwritten.
REQ-022 SHALL compare full 32-bit words; no masking.

Reset
REQ-023 SHALL, with reset_n=0, asynchronously force state=IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, captured_id=0, captured_ts=0, counter=0.
REQ-024 SHALL abandon any transaction in progress on reset assertion, with no done pulse; the first check after release requires a new start.

Structure
REQ-025 SHALL place the FSM state encoding and the SYSID_ADDR_ID=0 / SYSID_ADDR_TS=1 constants in a shared package, soc_sysid_pkg.
REQ-026 SHALL be implemented as one module with no sub-modules; the timeout counter stays inline.

Verification
REQ-027 SHALL cover the nominal check: slave with EXPECTED_ID=0, ts=1672894844, waitrequest=0, readdatavalid on the following cycle, then start -> done after 5 cycles with id_ok=1, ts_ok=1, timeout=0.
REQ-028 SHALL cover a timestamp mismatch: slave returns ts=32'h12345678 -> done with id_ok=1, ts_ok=0, captured_ts=32'h12345678.
REQ-029 SHALL cover backpressure: waitrequest held for 3 cycles per read -> avm_read/avm_address stable for those cycles, correct captures, done with both ok=1.
REQ-030 SHALL cover timeout: TIMEOUT_CYCLES=8, readdatavalid never asserted -> timeout=1, done pulse, id_ok=ts_ok=0, avm_read low within 8 cycles.
REQ-031 SHALL cover a reset during WAIT_TS: reset_n pulsed low -> all outputs at reset values, no done pulse; a later start gives a full correct check.
REQ-032 SHALL cover start while busy: start pulses in REQ_ID and in WAIT_ID -> exactly one done pulse per accepted start.
